store_queue: RTL
================

# store_queue

Parametrised store path for the RISC-V core, replacing single-bit MemWrite decoding with a buffered, handshaked store unit. It decodes store opcode/funct3 at issue, checks alignment, generates byte enables and lane-shifted write data, and holds up to DEPTH pending stores in a FIFO. The FIFO drains to data memory over a req/ack handshake. It sits between the execute stage and the data-memory port.

## Interface
- XLEN, 32: data width; fixed at 32 (4 byte lanes).
- AW, 32: byte-address width.
- DEPTH, 4: queue entries; power of two, ≥2.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  execute stage presents an instruction.
- issue_ready  out  1  queue can accept a store (= !full).
- op  in  7  instruction opcode.
- funct3  in  3  instruction funct3.
- addr  in  AW  byte address.
- wdata  in  XLEN  rs2 value, unshifted.
- st_err  out  1  one-cycle pulse: illegal or misaligned store dropped.
- mem_req  out  1  head entry valid toward memory.
- mem_addr  out  AW  head word address, addr[1:0]=0.
- mem_wdata  out  XLEN  head data, lane-shifted.
- mem_be  out  4  head byte enables.
- mem_ack  in  1  memory accepted head this cycle.
- ld_addr  in  AW  pending-load byte address (STQ_LOAD_CHECK_EN only).
- ld_conflict  out  1  a queued store hits ld_addr's word (STQ_LOAD_CHECK_EN only).

## Operation
- Enqueue condition: issue_valid && issue_ready && op==7'b0100011 && legal && aligned. All other opcodes (lw, R, I, branch, jal, jalr, GCD 0000000, LCM 1111111) are ignored: no enqueue, no st_err.
- funct3 000 sb: be = 4'b0001<<addr[1:0], data = wdata[7:0] replicated to all lanes.
- funct3 001 sh: requires addr[0]==0; be = 4'b0011<<addr[1:0], data = wdata[15:0] replicated.
- funct3 010 sw: requires addr[1:0]==0; be = 4'b1111, data = wdata.
- Other funct3, or misaligned sh/sw, with issue_valid && issue_ready: drop, st_err=1 next cycle for exactly one cycle.
- Store opcode with issue_ready=0: no enqueue, no st_err; upstream must hold.
- Storage: circular buffer, wr_ptr/rd_ptr of $clog2(DEPTH) bits wrapping DEPTH-1→0; count $clog2(DEPTH)+1 bits.
- Drain: mem_req = (count!=0); mem_addr/mem_wdata/mem_be driven from head entry, stable while mem_req && !mem_ack. mem_ack while mem_req=0 is ignored.
- Simultaneous enqueue and pop: count unchanged, both pointers advance.
- full = (count==DEPTH); issue_ready ignores same-cycle mem_ack (no pass-through when full).
- Strict FIFO order; no merging, no bypass of stores.

## Timing
- Reset (async assert, sync release): count=0, pointers=0, issue_ready=1, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, st_err=0, ld_conflict=0. Reset mid-handshake discards all entries, including an unacknowledged head.
- Enqueue latency: store accepted at edge N appears on mem_req in cycle N+1 (empty queue).
- Pop on ack at edge M; next entry presented in cycle M+1 with no idle cycle.
- Sustained throughput: one store per cycle when mem_ack held high.
- issue_ready deasserts the cycle after the DEPTH-th enqueue; reasserts the cycle after the pop that leaves count<DEPTH.
- st_err is registered: one cycle after the offending issue.

## Configuration
- STQ_LOAD_CHECK_EN defined: ld_conflict = combinational OR over valid entries of (entry word address == ld_addr[AW-1:2]); hazard unit stalls the load while asserted. An entry popped at edge M no longer counts from cycle M+1.
- Undefined: ld_addr unused, ld_conflict tied 0, no compare logic synthesised.

## Test plan
- Reset then sw addr=0x100 wdata=0xDEADBEEF, mem_ack held 1 -> next cycle mem_req=1, mem_addr=0x100, mem_be=4'b1111, mem_wdata=0xDEADBEEF; count returns to 0.
- sb addr=0x203 wdata=0x000000A5 -> mem_addr=0x200, mem_be=4'b1000, mem_wdata=0xA5A5A5A5; sh addr=0x202 wdata=0x1234 -> mem_be=4'b1100, mem_wdata=0x12341234.
- mem_ack=0, issue five sw with DEPTH=4 -> issue_ready=0 after 4th, 5th held; release ack -> addresses drained in issue order, pointer wrap verified, no loss.
- sw addr=0x102, sh addr=0x101, funct3=011 store -> each gives one-cycle st_err, nothing enqueued; lw/GCD/LCM opcodes -> no st_err, no enqueue.
- Full queue, simultaneous mem_ack and store issue -> store held (issue_ready=0), count drops to 3; accepted next cycle.
- STQ_LOAD_CHECK_EN: queue sw 0x300, ld_addr=0x302 -> ld_conflict=1; after ack pop -> 0 next cycle; async rst_n low mid-handshake -> mem_req=0 immediately.

Source files
------------

// File: rtl/store_queue.sv
// Buffered store unit: decodes RISC-V stores, aligns data/byte enables and drains them in order
// to data memory over a req/ack handshake. Define STQ_LOAD_CHECK_EN to add the load-hazard compare.
module store_queue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned AW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [6:0]      op,
  input  logic [2:0]      funct3,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] wdata,
  output logic            st_err,
  output logic            mem_req,
  output logic [AW-1:0]   mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ack,
  input  logic [AW-1:0]   ld_addr,
  output logic            ld_conflict
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned WAW = AW - 2;
  localparam logic [6:0]  OP_STORE = 7'b0100011;

  typedef struct packed {
    logic [WAW-1:0]  waddr;
    logic [XLEN-1:0] data;
    logic [3:0]      be;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_issue_ready;
  logic            r_mem_req;
  logic [AW-1:0]   r_mem_addr;
  logic [XLEN-1:0] r_mem_wdata;
  logic [3:0]      r_mem_be;
  logic            r_st_err;

  logic            w_ok;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_data;
  entry_t          w_new;
  logic            w_take;
  logic            w_enq;
  logic            w_err;
  logic            w_pop;
  logic [CW-1:0]   w_count_nxt;
  logic [PW-1:0]   w_rd_nxt;
  entry_t          w_head_nxt;

  // Store decode: legality, alignment, byte enables and lane replication
  always_comb begin
    w_ok   = 1'b0;
    w_be   = 4'b0000;
    w_data = '0;
    case (funct3)
      3'b000: begin
        w_ok   = 1'b1;
        w_be   = 4'b0001 << addr[1:0];
        w_data = XLEN'({4{wdata[7:0]}});
      end
      3'b001: begin
        w_ok   = ~addr[0];
        w_be   = 4'b0011 << addr[1:0];
        w_data = XLEN'({2{wdata[15:0]}});
      end
      3'b010: begin
        w_ok   = (addr[1:0] == 2'b00);
        w_be   = 4'b1111;
        w_data = wdata;
      end
      default: begin
        w_ok   = 1'b0;
        w_be   = 4'b0000;
        w_data = '0;
      end
    endcase
  end

  assign w_new.waddr = addr[AW-1:2];
  assign w_new.data  = w_data;
  assign w_new.be    = w_be;

  assign w_take = issue_valid && r_issue_ready && (op == OP_STORE);
  assign w_enq  = w_take && w_ok;
  assign w_err  = w_take && !w_ok;
  assign w_pop  = r_mem_req && mem_ack;

  assign w_count_nxt = r_count + CW'(w_enq) - CW'(w_pop);
  assign w_rd_nxt    = r_rd_ptr + PW'(w_pop);

  // The new head is the incoming store when it lands in the slot the read pointer moves to
  assign w_head_nxt = (w_enq && (r_wr_ptr == w_rd_nxt)) ? w_new : r_mem[w_rd_nxt];

  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_wr_ptr] <= w_new;
  end

  // Pointers, occupancy and registered memory-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_issue_ready <= 1'b1;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_be      <= 4'b0000;
      r_st_err      <= 1'b0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
      r_rd_ptr      <= w_rd_nxt;
      r_count       <= w_count_nxt;
      r_issue_ready <= (w_count_nxt != CW'(DEPTH));
      r_mem_req     <= (w_count_nxt != '0);
      r_st_err      <= w_err;
      if (w_count_nxt != '0) begin
        r_mem_addr  <= {w_head_nxt.waddr, 2'b00};
        r_mem_wdata <= w_head_nxt.data;
        r_mem_be    <= w_head_nxt.be;
      end
    end
  end

  assign issue_ready = r_issue_ready;
  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_be      = r_mem_be;
  assign st_err      = r_st_err;

`ifdef STQ_LOAD_CHECK_EN
  logic [DEPTH-1:0] w_hit;

  // An entry is live when its distance from the head is below the occupancy
  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    logic [PW-1:0] w_off;
    assign w_off    = PW'(g) - r_rd_ptr;
    assign w_hit[g] = ({1'b0, w_off} < r_count) && (r_mem[g].waddr == ld_addr[AW-1:2]);
  end

  assign ld_conflict = |w_hit;
`else
  logic w_unused_ld;
  assign w_unused_ld = ^ld_addr;
  assign ld_conflict = 1'b0;
`endif

endmodule
